prbs_burst_sched: RTL

//  Two-requester round-robin scheduler for one shared lfsr_prbs_gen.
//  - Accepts a burst request (word count) from each requester.
//  - Drives the LFSR enable exactly once per word.
//  - Returns every word through a 2-entry valid/ready output buffer, tagged with requester id and last flag.
//  - Sits between the test/traffic engines and the PRBS generator; it is the only block driving its enable.

---
 rtl/prbs_burst_sched.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/prbs_burst_sched.sv
// prbs_burst_sched: two-requester round-robin burst scheduler for one shared PRBS LFSR.
// Each granted burst steps the LFSR once per word; words return through a 2-entry
// fall-through buffer tagged with requester id and last flag.
// Optional build macro PRBS_BURST_STATS_EN adds saturating per-requester word counters.
module prbs_burst_sched #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned LEN_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid,
    input  logic [2*LEN_W-1:0] req_len,
    output logic [1:0]         req_ready,
    output logic               lfsr_en,
    input  logic [WIDTH-1:0]   lfsr_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_id,
    output logic               out_last,
    output logic [1:0]         burst_done
`ifdef PRBS_BURST_STATS_EN
    ,
    output logic [31:0]        stat_words0,
    output logic [31:0]        stat_words1
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t                 r_state, w_state_nxt;
    logic [LEN_W-1:0]       r_rem;
    logic                   r_id;
    logic                   r_last_grant;
    logic [1:0]             r_zero_done;
    logic                   r_inflight;
    logic                   r_if_last;
    logic [1:0]             r_occ;
    logic [1:0][WIDTH-1:0]  r_buf_data;
    logic [1:0]             r_buf_id;
    logic [1:0]             r_buf_last;
    logic [WIDTH-1:0]       r_hold_data;
    logic                   r_hold_id;
    logic                   r_hold_last;

    logic                   w_grant_any;
    logic                   w_grant;
    logic [LEN_W-1:0]       w_glen;
    logic [1:0]             w_slots;
    logic                   w_pop;
    logic                   w_pop_buf;
    logic                   w_push;
    logic                   w_last_en;
    logic                   w_drain_done;
    logic [WIDTH-1:0]       w_head_data;
    logic                   w_head_id;
    logic                   w_head_last;

    // Arbitration: with both requesting, the one not granted last time wins.
    assign w_grant_any = |req_valid;
    assign w_grant     = (&req_valid) ? ~r_last_grant : req_valid[1];
    assign w_glen      = w_grant ? req_len[LEN_W +: LEN_W] : req_len[0 +: LEN_W];

    // Occupancy counts the in-flight word so the enable rule can never overflow the buffer.
    assign w_slots   = r_occ + {1'b0, r_inflight};
    assign out_valid = (r_occ != 2'd0) || r_inflight;
    assign w_pop     = out_valid && out_ready;
    assign w_pop_buf = w_pop && (r_occ != 2'd0);
    // An in-flight word popped straight off lfsr_data with an empty buffer is never stored.
    assign w_push    = r_inflight && !(w_pop && (r_occ == 2'd0));
    assign w_last_en = lfsr_en && (r_rem == LEN_W'(1));

    // Buffer head, falling through to the live LFSR word when the buffer is empty.
    assign w_head_data = (r_occ != 2'd0) ? r_buf_data[0] : lfsr_data;
    assign w_head_id   = (r_occ != 2'd0) ? r_buf_id[0]   : r_id;
    assign w_head_last = (r_occ != 2'd0) ? r_buf_last[0] : r_if_last;

    // Outputs hold their last presented value while nothing is valid.
    assign out_data = out_valid ? w_head_data : r_hold_data;
    assign out_id   = out_valid ? w_head_id   : r_hold_id;
    assign out_last = out_valid ? w_head_last : r_hold_last;

    assign burst_done = r_zero_done | ({2{w_drain_done}} & (r_id ? 2'b10 : 2'b01));

    // Next-state, grant pulse, LFSR enable and drain completion.
    always_comb begin
        w_state_nxt  = r_state;
        req_ready    = '0;
        lfsr_en      = 1'b0;
        w_drain_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant_any) begin
                    req_ready[w_grant] = 1'b1;
                    if (w_glen != '0) w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                lfsr_en = (r_rem != '0) && (w_slots < 2'd2);
                if ((r_rem == '0) || w_last_en) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if ((w_slots == 2'd0) || ((w_slots == 2'd1) && w_pop)) begin
                    w_drain_done = 1'b1;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM state, burst bookkeeping and zero-length completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_rem        <= '0;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
            r_zero_done  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_zero_done <= '0;
            if ((r_state == S_IDLE) && w_grant_any) begin
                r_id         <= w_grant;
                r_last_grant <= w_grant;
                r_rem        <= w_glen;
                if (w_glen == '0) r_zero_done <= w_grant ? 2'b10 : 2'b01;
            end else if (lfsr_en) begin
                r_rem <= r_rem - LEN_W'(1);
            end
        end
    end

    // In-flight tracking, 2-entry buffer and output hold registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight  <= 1'b0;
            r_if_last   <= 1'b0;
            r_occ       <= '0;
            r_buf_data  <= '0;
            r_buf_id    <= '0;
            r_buf_last  <= '0;
            r_hold_data <= '0;
            r_hold_id   <= 1'b0;
            r_hold_last <= 1'b0;
        end else begin
            r_inflight <= lfsr_en;
            r_if_last  <= w_last_en;
            if (w_pop_buf) begin
                r_buf_data[0] <= r_buf_data[1];
                r_buf_id[0]   <= r_buf_id[1];
                r_buf_last[0] <= r_buf_last[1];
                if (w_push) begin
                    if (r_occ == 2'd1) begin
                        r_buf_data[0] <= lfsr_data;
                        r_buf_id[0]   <= r_id;
                        r_buf_last[0] <= r_if_last;
                    end else begin
                        r_buf_data[1] <= lfsr_data;
                        r_buf_id[1]   <= r_id;
                        r_buf_last[1] <= r_if_last;
                    end
                end else begin
                    r_occ <= r_occ - 2'd1;
                end
            end else if (w_push) begin
                if (r_occ == 2'd0) begin
                    r_buf_data[0] <= lfsr_data;
                    r_buf_id[0]   <= r_id;
                    r_buf_last[0] <= r_if_last;
                end else begin
                    r_buf_data[1] <= lfsr_data;
                    r_buf_id[1]   <= r_id;
                    r_buf_last[1] <= r_if_last;
                end
                r_occ <= r_occ + 2'd1;
            end
            if (out_valid) begin
                r_hold_data <= w_head_data;
                r_hold_id   <= w_head_id;
                r_hold_last <= w_head_last;
            end
        end
    end

`ifdef PRBS_BURST_STATS_EN
    // Saturating count of words popped per requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_words0 <= '0;
            stat_words1 <= '0;
        end else if (w_pop) begin
            if (out_id) begin
                if (stat_words1 != '1) stat_words1 <= stat_words1 + 32'd1;
            end else begin
                if (stat_words0 != '1) stat_words0 <= stat_words0 + 32'd1;
            end
        end
    end
`endif

endmodule
